// File: rtl/output_port_scheduler.sv
// Output-port scheduler: round-robin over input FIFOs whose head targets
// this port, holding the grant for a whole packet and forwarding it framed.
//
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   fifo_empty   per-input FIFO empty flag
//   header_in    per-input head header, [7:6] dest port, [3:0] payload LEN
//   fifo_data    per-input FIFO data_out, valid one cycle after rd_en
//   rd_en        per-input read strobe, at most one bit high
//   out_ready    downstream accepts a word next cycle
//   out_valid    out_data valid this cycle
//   out_data     forwarded word (0 when not valid)
//   out_sop      header word of a packet
//   out_eop      last word of a packet
//   grant        one-hot current owner, 0 when idle
//   busy         a packet transfer is in progress

package packet_pkg;
    localparam int DATA_WIDTH = 8;
endpackage

module output_port_scheduler #(
    parameter int NUM_PORTS  = 4,
    parameter int PORT_ID    = 0,
    parameter int DATA_WIDTH = packet_pkg::DATA_WIDTH
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NUM_PORTS-1:0]                 fifo_empty,
    input  logic [NUM_PORTS-1:0][7:0]            header_in,
    input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] fifo_data,
    output logic [NUM_PORTS-1:0]                 rd_en,
    input  logic                                 out_ready,
    output logic                                 out_valid,
    output logic [DATA_WIDTH-1:0]                out_data,
    output logic                                 out_sop,
    output logic                                 out_eop,
    output logic [NUM_PORTS-1:0]                 grant,
    output logic                                 busy
);

    localparam int IW = $clog2(NUM_PORTS);

    typedef enum logic {
        IDLE,
        XFER
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_PORTS-1:0] grant_q, grant_d;
    logic [IW-1:0]        gidx_q, gidx_d;
    logic [IW-1:0]        last_q, last_d;
    logic [4:0]           rem_q, rem_d;
    logic                 first_q, first_d;
    logic [IW-1:0]        gd_q;
    logic                 valid_q, sop_q, eop_q;

    logic [NUM_PORTS-1:0] req;
    logic                 pick_valid;
    logic [IW-1:0]        pick_idx;
    logic                 rd_any;
    logic                 hdr_unused;

    // Header bits [5:4] carry nothing for scheduling.
    assign hdr_unused = ^header_in;

    always_comb begin
        req = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            req[i] = !fifo_empty[i] && (header_in[i][7:6] == 2'(PORT_ID));
        end
    end

    // Scan upward from the port after the last winner, so the port that
    // just finished is considered last.
    always_comb begin
        logic [IW-1:0] cand;
        cand       = '0;
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            cand = IW'((int'(last_q) + k) % NUM_PORTS);
            if (!pick_valid && req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        last_d  = last_q;
        rem_d   = rem_q;
        first_d = first_q;
        rd_en   = '0;
        rd_any  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = XFER;
                    grant_d = NUM_PORTS'(1) << pick_idx;
                    gidx_d  = pick_idx;
                    last_d  = pick_idx;
                    rem_d   = {1'b0, header_in[pick_idx][3:0]} + 5'd1;
                    first_d = 1'b1;
                end
            end
            XFER: begin
                rd_any = out_ready && !fifo_empty[gidx_q] && (rem_q != 5'd0);
                rd_en[gidx_q] = rd_any;
                if (rd_any) begin
                    rem_d   = rem_q - 5'd1;
                    first_d = 1'b0;
                end
                // Leave on the same edge as the last read, so the final
                // word appears during the idle gap cycle.
                if (rem_d == 5'd0) begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            last_q  <= IW'(NUM_PORTS - 1);
            rem_q   <= '0;
            first_q <= 1'b0;
            gd_q    <= '0;
            valid_q <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            last_q  <= last_d;
            rem_q   <= rem_d;
            first_q <= first_d;
            valid_q <= rd_any;
            sop_q   <= rd_any && first_q;
            eop_q   <= rd_any && (rem_q == 5'd1);
            if (rd_any) begin
                gd_q <= gidx_q;
            end
        end
    end

    assign out_valid = valid_q;
    assign out_sop   = sop_q;
    assign out_eop   = eop_q;
    assign out_data  = valid_q ? fifo_data[gd_q] : '0;
    assign grant     = grant_q;
    assign busy      = (state_q == XFER);

endmodule

// File: tb/tb_output_port_scheduler.sv
// Bench for output_port_scheduler: FIFO models per input, scoreboard of
// expected output words, vector table plus corner-case sequences.
module tb_output_port_scheduler;

    localparam int NP = 4;
    localparam int DW = 8;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [NP-1:0]          fifo_empty;
    logic [NP-1:0][7:0]     header_in;
    logic [NP-1:0][DW-1:0]  fifo_data;
    logic [NP-1:0]          rd_en;
    logic                   out_ready;
    logic                   out_valid;
    logic [DW-1:0]          out_data;
    logic                   out_sop;
    logic                   out_eop;
    logic [NP-1:0]          grant;
    logic                   busy;

    output_port_scheduler #(
        .NUM_PORTS (NP),
        .PORT_ID   (0),
        .DATA_WIDTH(DW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .fifo_empty(fifo_empty),
        .header_in (header_in),
        .fifo_data (fifo_data),
        .rd_en     (rd_en),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sop   (out_sop),
        .out_eop   (out_eop),
        .grant     (grant),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic       sop;
        logic       eop;
    } word_t;

    typedef struct {
        int         port;
        int         dst;
        int         len;
        logic [3:0] gnt;
        int         words;
    } vec_t;

    word_t         sb[$];
    logic [7:0]    fq[NP][$];
    logic [NP-1:0] hold_empty;
    logic [NP-1:0] snap;
    logic [NP-1:0] rd_mask;
    logic [NP-1:0] prev_grant;
    logic [NP-1:0] glog_g[$];
    int            glog_c[$];
    int            total, bad, cyc, rd_cnt, words, first_valid, multi;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic refresh();
        for (int i = 0; i < NP; i++) begin
            fifo_empty[i] = hold_empty[i] || (fq[i].size() == 0);
            header_in[i]  = (fq[i].size() != 0) ? fq[i][0] : 8'h00;
        end
    endtask

    task automatic flush();
        for (int i = 0; i < NP; i++) fq[i].delete();
        refresh();
    endtask

    task automatic clear_stats();
        rd_cnt      = 0;
        rd_mask     = '0;
        multi       = 0;
        words       = 0;
        first_valid = -1;
        glog_g.delete();
        glog_c.delete();
    endtask

    // Observe at the falling edge, then model the FIFO pops just after
    // the rising edge, as a registered FIFO would.
    task automatic tick();
        word_t w;
        @(negedge clk);
        cyc++;
        if ($countones(rd_en) > 1) multi++;
        if (rd_en != '0) rd_cnt++;
        rd_mask |= rd_en;
        if (grant != '0 && prev_grant == '0) begin
            glog_g.push_back(grant);
            glog_c.push_back(cyc);
        end
        prev_grant = grant;
        if (out_valid) begin
            if (first_valid < 0) first_valid = cyc;
            words++;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_word: got %0h, none expected",
                         out_data);
            end else begin
                w = sb.pop_front();
                chk("word", {out_data, out_sop, out_eop},
                    {w.data, w.sop, w.eop});
            end
        end
        snap = rd_en;
        @(posedge clk);
        #1;
        for (int i = 0; i < NP; i++) begin
            if (snap[i]) begin
                if (fq[i].size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL pop_empty: port %0d read, 0 words", i);
                end else begin
                    fifo_data[i] = fq[i].pop_front();
                end
            end
        end
        refresh();
    endtask

    task automatic push_pkt(input int port, input int dst, input int len,
                            input bit expect_out);
        logic [7:0] h;
        logic [7:0] d;
        h = {dst[1:0], 2'($urandom), len[3:0]};
        fq[port].push_back(h);
        if (expect_out) sb.push_back('{data: h, sop: 1'b1, eop: (len == 0)});
        for (int k = 1; k <= len; k++) begin
            d = 8'($urandom);
            fq[port].push_back(d);
            if (expect_out)
                sb.push_back('{data: d, sop: 1'b0, eop: (k == len)});
        end
        refresh();
    endtask

    task automatic drain(input int maxc);
        for (int i = 0; i < maxc; i++) begin
            tick();
            if (i >= 4 && sb.size() == 0 && !busy) break;
        end
        chk("drain_left", sb.size(), 0);
        chk("idle_at_end", {busy, grant}, 0);
        chk("rd_onehot", multi, 0);
    endtask

    logic [3:0] rr_exp[5];
    vec_t       vt[4];
    int         t0;

    initial begin
        total      = 0;
        bad        = 0;
        cyc        = 0;
        out_ready  = 1'b1;
        hold_empty = '0;
        fifo_data  = '0;
        prev_grant = '0;
        rst_n      = 1'b0;
        flush();
        clear_stats();

        tick();
        tick();
        chk("reset_state",
            {out_valid, out_sop, out_eop, out_data, grant, rd_en, busy}, 0);
        rst_n = 1'b1;
        tick();
        chk("idle_no_req", {busy, grant, rd_en, out_valid}, 0);

        // Round-robin from reset, single-word packets
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        clear_stats();
        push_pkt(0, 0, 0, 1);
        push_pkt(1, 0, 0, 1);
        push_pkt(2, 0, 0, 1);
        push_pkt(3, 0, 0, 1);
        push_pkt(0, 0, 0, 1);
        drain(40);
        chk("rr_count", glog_g.size(), 5);
        for (int k = 0; k < glog_g.size() && k < 5; k++) begin
            chk("rr_grant", glog_g[k], rr_exp[k]);
            if (k > 0) chk("rr_gap", glog_c[k] - glog_c[k-1], 2);
        end
        chk("rr_words", words, 5);

        // Single-packet vectors
        vt[0] = '{port: 2, dst: 0, len: 3, gnt: 4'b0100, words: 4};
        vt[1] = '{port: 1, dst: 2, len: 2, gnt: 4'b0000, words: 0};
        vt[2] = '{port: 3, dst: 0, len: 1, gnt: 4'b1000, words: 2};
        vt[3] = '{port: 0, dst: 0, len: 0, gnt: 4'b0001, words: 1};
        for (int v = 0; v < 4; v++) begin
            clear_stats();
            t0 = cyc;
            push_pkt(vt[v].port, vt[v].dst, vt[v].len, vt[v].dst == 0);
            drain(60);
            chk("vec_grant", (glog_g.size() != 0) ? glog_g[0] : 4'b0,
                vt[v].gnt);
            chk("vec_rd_pulses", rd_cnt, vt[v].words);
            chk("vec_words", words, vt[v].words);
            if (vt[v].gnt != 4'b0000) begin
                chk("vec_grant_lat",
                    (glog_c.size() != 0) ? glog_c[0] - t0 : -1, 2);
                chk("vec_valid_lat", first_valid - t0, 3);
            end
            flush();
        end

        // Destination filter with two heads present
        clear_stats();
        push_pkt(1, 2, 2, 0);
        push_pkt(3, 0, 2, 1);
        drain(40);
        chk("filt_grants", glog_g.size(), 1);
        chk("filt_grant", (glog_g.size() != 0) ? glog_g[0] : 4'b0,
            4'b1000);
        chk("filt_rd1", rd_mask[1], 0);
        chk("filt_words", words, 3);
        flush();

        // Backpressure then FIFO-empty stall mid-packet
        clear_stats();
        push_pkt(2, 0, 5, 1);
        for (int i = 0; i < 20 && rd_cnt < 2; i++) tick();
        chk("stall_pre_reads", rd_cnt, 2);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_ready_rd", snap, 0);
            chk("stall_ready_grant", grant, 4'b0100);
        end
        out_ready = 1'b1;
        hold_empty[2] = 1'b1;
        refresh();
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("stall_empty_rd", snap, 0);
            chk("stall_empty_grant", grant, 4'b0100);
        end
        hold_empty = '0;
        refresh();
        drain(40);
        chk("stall_words", words, 6);
        chk("stall_rd_pulses", rd_cnt, 6);

        // Maximum length packet
        clear_stats();
        push_pkt(1, 0, 15, 1);
        drain(60);
        chk("max_words", words, 16);
        chk("max_rd_pulses", rd_cnt, 16);

        // Reset in the middle of a packet
        clear_stats();
        push_pkt(0, 0, 7, 1);
        for (int i = 0; i < 20 && rd_cnt < 2; i++) tick();
        rst_n = 1'b0;
        #1;
        chk("rst_mid_outputs",
            {out_valid, out_sop, out_eop, out_data, grant, rd_en, busy}, 0);
        flush();
        sb.delete();
        tick();
        tick();
        rst_n = 1'b1;
        clear_stats();
        push_pkt(0, 0, 0, 1);
        push_pkt(3, 0, 0, 1);
        drain(40);
        chk("rst_prio_first", (glog_g.size() > 0) ? glog_g[0] : 4'b0,
            4'b0001);
        chk("rst_prio_second", (glog_g.size() > 1) ? glog_g[1] : 4'b0,
            4'b1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
